// File: rtl/breakout_pkg.sv
// Shared geometry defaults, block colours and probe FSM state encoding
// for the breakout block controller.
package breakout_pkg;

  localparam int DEF_BLOCK_W = 40;
  localparam int DEF_BLOCK_H = 20;
  localparam int DEF_NUM_X   = 10;
  localparam int DEF_NUM_Y   = 4;
  localparam int DEF_SPACING = 5;
  localparam int DEF_START_X = 50;
  localparam int DEF_START_Y = 30;

  localparam int COORD_W = 10;
  localparam int ROW_W   = 2;
  localparam int COL_W   = 4;
  localparam int IDX_W   = 6;
  localparam int SCORE_W = 16;

  // 12-bit RGB, one colour per block row, used by the pixel renderer.
  localparam logic [11:0] COLOR_ROW0 = 12'hF44;
  localparam logic [11:0] COLOR_ROW1 = 12'hF94;
  localparam logic [11:0] COLOR_ROW2 = 12'h4F4;
  localparam logic [11:0] COLOR_ROW3 = 12'h48F;
  localparam logic [11:0] COLOR_BG   = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOCATE = 3'd1,
    ST_TEST   = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_ACK    = 3'd4
  } probe_state_t;

  function automatic logic [11:0] row_color(input logic [ROW_W-1:0] row);
    logic [11:0] c;
    c = COLOR_BG;
    case (row)
      2'd0: c = COLOR_ROW0;
      2'd1: c = COLOR_ROW1;
      2'd2: c = COLOR_ROW2;
      2'd3: c = COLOR_ROW3;
      default: c = COLOR_BG;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/breakout_grid_locate.sv
// Combinational point-to-block mapping: row/column of the grid cell under
// (x,y) and whether the point lies on the block itself rather than a gap.
module breakout_grid_locate
  import breakout_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int BLOCK_H = DEF_BLOCK_H,
  parameter int NUM_X   = DEF_NUM_X,
  parameter int NUM_Y   = DEF_NUM_Y,
  parameter int SPACING = DEF_SPACING,
  parameter int START_X = DEF_START_X,
  parameter int START_Y = DEF_START_Y
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_in_block,
  output logic [ROW_W-1:0]   o_row,
  output logic [COL_W-1:0]   o_col
);

  localparam int PITCH_X = BLOCK_W + SPACING;
  localparam int PITCH_Y = BLOCK_H + SPACING;
  // Right/bottom limits exclude the trailing gap after the last block.
  localparam int END_X   = START_X + NUM_X * PITCH_X - SPACING;
  localparam int END_Y   = START_Y + NUM_Y * PITCH_Y - SPACING;

  logic [COORD_W-1:0] w_off_x;
  logic [COORD_W-1:0] w_off_y;
  logic [COORD_W-1:0] w_mod_x;
  logic [COORD_W-1:0] w_mod_y;

  assign w_off_x = i_x - COORD_W'(START_X);
  assign w_off_y = i_y - COORD_W'(START_Y);
  assign w_mod_x = w_off_x % COORD_W'(PITCH_X);
  assign w_mod_y = w_off_y % COORD_W'(PITCH_Y);

  assign o_col = COL_W'(w_off_x / COORD_W'(PITCH_X));
  assign o_row = ROW_W'(w_off_y / COORD_W'(PITCH_Y));

  assign o_in_block = (i_x >= COORD_W'(START_X)) && (i_x < COORD_W'(END_X)) &&
                      (i_y >= COORD_W'(START_Y)) && (i_y < COORD_W'(END_Y)) &&
                      (w_mod_x < COORD_W'(BLOCK_W)) && (w_mod_y < COORD_W'(BLOCK_H));

endmodule

// File: rtl/breakout_block_ctrl.sv
// Breakout block field: alive bits, collision probe FSM, render lookup, score.
// Define BREAKOUT_ROW_SCORE_EN to weight points by row (top row worth most).
module breakout_block_ctrl
  import breakout_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int BLOCK_H = DEF_BLOCK_H,
  parameter int NUM_X   = DEF_NUM_X,
  parameter int NUM_Y   = DEF_NUM_Y,
  parameter int SPACING = DEF_SPACING,
  parameter int START_X = DEF_START_X,
  parameter int START_Y = DEF_START_Y
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               level_start,
  input  logic               hit_req,
  input  logic [COORD_W-1:0] hit_x,
  input  logic [COORD_W-1:0] hit_y,
  output logic               hit_busy,
  output logic               hit_ack,
  output logic               hit_valid,
  output logic [ROW_W-1:0]   hit_row,
  output logic [COL_W-1:0]   hit_col,
  input  logic [COORD_W-1:0] hCount,
  input  logic [COORD_W-1:0] vCount,
  output logic               block_on,
  output logic [ROW_W-1:0]   pix_row,
  output logic [SCORE_W-1:0] score,
  output logic [IDX_W-1:0]   blocks_left,
  output logic               level_clear
);

  localparam int NUM_BLOCKS = NUM_X * NUM_Y;

  probe_state_t r_state, w_state_next;

  logic [COORD_W-1:0]    r_hx, r_hy;
  logic                  r_in_block, r_hit_flag;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic [NUM_BLOCKS-1:0] r_alive;
  logic                  r_busy, r_hit_ack, r_hit_valid, r_level_clear;
  logic [ROW_W-1:0]      r_hit_row, r_pix_row;
  logic [COL_W-1:0]      r_hit_col;
  logic                  r_block_on;
  logic [SCORE_W-1:0]    r_score;
  logic [IDX_W-1:0]      r_blocks_left;

  logic                  w_p_in, w_r_in, w_p_live, w_r_live;
  logic [ROW_W-1:0]      w_p_row, w_r_row;
  logic [COL_W-1:0]      w_p_col, w_r_col;
  logic [IDX_W-1:0]      w_p_idx, w_r_idx;
  logic [SCORE_W-1:0]    w_points;
  logic [SCORE_W:0]      w_score_sum;

  breakout_grid_locate #(
    .BLOCK_W(BLOCK_W), .BLOCK_H(BLOCK_H), .NUM_X(NUM_X), .NUM_Y(NUM_Y),
    .SPACING(SPACING), .START_X(START_X), .START_Y(START_Y)
  ) u_probe_locate (
    .i_x(r_hx), .i_y(r_hy), .o_in_block(w_p_in), .o_row(w_p_row), .o_col(w_p_col)
  );

  breakout_grid_locate #(
    .BLOCK_W(BLOCK_W), .BLOCK_H(BLOCK_H), .NUM_X(NUM_X), .NUM_Y(NUM_Y),
    .SPACING(SPACING), .START_X(START_X), .START_Y(START_Y)
  ) u_render_locate (
    .i_x(hCount), .i_y(vCount), .o_in_block(w_r_in), .o_row(w_r_row), .o_col(w_r_col)
  );

  // Off-grid row/col can exceed the field, so gate the index to stay in range.
  assign w_p_idx  = r_in_block ? IDX_W'(IDX_W'(r_row) * IDX_W'(NUM_X) + IDX_W'(r_col)) : '0;
  assign w_r_idx  = w_r_in ? IDX_W'(IDX_W'(w_r_row) * IDX_W'(NUM_X) + IDX_W'(w_r_col)) : '0;
  assign w_p_live = r_in_block && r_alive[w_p_idx];
  assign w_r_live = w_r_in && r_alive[w_r_idx];

`ifdef BREAKOUT_ROW_SCORE_EN
  assign w_points = SCORE_W'(NUM_Y) - SCORE_W'(r_row);
`else
  assign w_points = SCORE_W'(1);
`endif
  assign w_score_sum = {1'b0, r_score} + {1'b0, w_points};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (hit_req) w_state_next = ST_LOCATE;
      ST_LOCATE: w_state_next = ST_TEST;
      ST_TEST:   w_state_next = w_p_live ? ST_CLEAR : ST_ACK;
      ST_CLEAR:  w_state_next = ST_ACK;
      ST_ACK:    w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (level_start) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hx <= '0; r_hy <= '0;
      r_in_block <= 1'b0; r_row <= '0; r_col <= '0; r_hit_flag <= 1'b0;
      r_alive <= '1; r_blocks_left <= IDX_W'(NUM_BLOCKS); r_score <= '0;
      r_busy <= 1'b0; r_hit_ack <= 1'b0; r_hit_valid <= 1'b0;
      r_hit_row <= '0; r_hit_col <= '0; r_level_clear <= 1'b0;
    end else if (level_start) begin
      r_alive <= '1; r_blocks_left <= IDX_W'(NUM_BLOCKS);
      r_level_clear <= 1'b0; r_busy <= 1'b0; r_hit_ack <= 1'b0;
    end else begin
      r_hit_ack     <= 1'b0;
      r_level_clear <= r_level_clear | (r_blocks_left == '0);
      case (r_state)
        ST_IDLE: if (hit_req) begin
          r_hx <= hit_x; r_hy <= hit_y; r_busy <= 1'b1;
        end
        ST_LOCATE: begin
          r_in_block <= w_p_in; r_row <= w_p_row; r_col <= w_p_col;
        end
        ST_TEST: r_hit_flag <= w_p_live;
        ST_CLEAR: begin
          r_alive[w_p_idx] <= 1'b0;
          r_blocks_left    <= r_blocks_left - IDX_W'(1);
          r_score          <= w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
        end
        ST_ACK: begin
          r_hit_ack <= 1'b1; r_hit_valid <= r_hit_flag;
          r_hit_row <= r_row; r_hit_col <= r_col; r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Render lookup runs every cycle regardless of probe activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_block_on <= 1'b0; r_pix_row <= '0;
    end else begin
      r_block_on <= w_r_live;
      r_pix_row  <= w_r_live ? w_r_row : '0;
    end
  end

  assign hit_busy    = r_busy;
  assign hit_ack     = r_hit_ack;
  assign hit_valid   = r_hit_valid;
  assign hit_row     = r_hit_row;
  assign hit_col     = r_hit_col;
  assign block_on    = r_block_on;
  assign pix_row     = r_pix_row;
  assign score       = r_score;
  assign blocks_left = r_blocks_left;
  assign level_clear = r_level_clear;

endmodule

// File: tb/tb_breakout_block_ctrl.sv
// Bench for breakout_block_ctrl: directed vector table, hand-written corner
// sequences and randomized probes against a geometric reference model.
module tb_breakout_block_ctrl;

  logic       clk = 1'b0;
  logic       reset, level_start, hit_req;
  logic [9:0] hit_x, hit_y, hCount, vCount;
  logic       hit_busy, hit_ack, hit_valid, block_on, level_clear;
  logic [1:0] hit_row, pix_row;
  logic [3:0] hit_col;
  logic [15:0] score;
  logic [5:0] blocks_left;

  breakout_block_ctrl dut (
    .clk(clk), .reset(reset), .level_start(level_start), .hit_req(hit_req),
    .hit_x(hit_x), .hit_y(hit_y), .hit_busy(hit_busy), .hit_ack(hit_ack),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .hCount(hCount), .vCount(vCount), .block_on(block_on), .pix_row(pix_row),
    .score(score), .blocks_left(blocks_left), .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit alive_m[40];
  int score_m, left_m;
  int bl0_cyc, lc_cyc;

  typedef struct {
    int x; int y; bit valid; int row; int col; int lat;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int points(input int row);
`ifdef BREAKOUT_ROW_SCORE_EN
    return 4 - row;
`else
    return 1 + 0 * row;
`endif
  endfunction

  // Geometry straight from the field description: 45 px column pitch, 25 px row pitch.
  function automatic void locate(input int x, input int y, output bit inb, output int row, output int col);
    int ox, oy;
    ox = x - 50; oy = y - 30;
    inb = (x >= 50) && (x < 495) && (y >= 30) && (y < 125) && (ox % 45 < 40) && (oy % 25 < 20);
    row = inb ? oy / 25 : 0;
    col = inb ? ox / 45 : 0;
  endfunction

  task automatic model_reload();
    for (int i = 0; i < 40; i++) alive_m[i] = 1'b1;
    left_m = 40;
  endtask

  // Starts and ends on a negedge; returns what the DUT reported.
  task automatic probe(input int x, input int y, output int lat, output bit v, output int row, output int col);
    bit inb, hit;
    int mrow, mcol, cyc;
    locate(x, y, inb, mrow, mcol);
    hit = inb && alive_m[mrow * 10 + mcol];
    hit_req = 1'b1; hit_x = 10'(x); hit_y = 10'(y);
    @(negedge clk);
    hit_req = 1'b0;
    check("busy_after_accept", 32'(hit_busy), 32'd1);
    cyc = 0; bl0_cyc = -1; lc_cyc = -1;
    while (hit_ack !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (blocks_left == 6'd0 && bl0_cyc < 0) bl0_cyc = cyc;
      if (level_clear === 1'b1 && lc_cyc < 0) lc_cyc = cyc;
    end
    if (hit) begin
      alive_m[mrow * 10 + mcol] = 1'b0;
      left_m--;
      score_m = (score_m + points(mrow) > 65535) ? 65535 : score_m + points(mrow);
    end
    lat = cyc; v = hit_valid; row = int'(hit_row); col = int'(hit_col);
    check("probe_latency", 32'(cyc), hit ? 32'd4 : 32'd3);
    check("probe_valid", 32'(hit_valid), 32'(hit));
    if (hit) begin
      check("probe_row", 32'(hit_row), 32'(mrow));
      check("probe_col", 32'(hit_col), 32'(mcol));
    end
    check("blocks_left", 32'(blocks_left), 32'(left_m));
    check("score", 32'(score), 32'(score_m));
    $display("probe x=%0d y=%0d lat=%0d valid=%0d row=%0d col=%0d left=%0d score=%0d",
             x, y, cyc, hit_valid, hit_row, hit_col, blocks_left, score);
    @(negedge clk);
    check("ack_one_cycle", 32'(hit_ack), 32'd0);
  endtask

  task automatic render_check(input int x, input int y);
    bit inb; int row, col;
    hCount = 10'(x); vCount = 10'(y);
    @(negedge clk);
    locate(x, y, inb, row, col);
    inb = inb && alive_m[row * 10 + col];
    check("render_block_on", 32'(block_on), 32'(inb));
    check("render_pix_row", 32'(pix_row), inb ? 32'(row) : 32'd0);
    $display("render h=%0d v=%0d block_on=%0d pix_row=%0d", x, y, block_on, pix_row);
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (hit_ack === 1'b1) acks++;
    end
  endtask

  initial begin
    int lat, row, col, acks, prev_left, x, y;
    bit v;

    vecs[0] = '{55, 35, 1, 0, 0, 4};
    vecs[1] = '{55, 35, 0, 0, 0, 3};
    vecs[2] = '{92, 35, 0, 0, 0, 3};
    vecs[3] = '{600, 200, 0, 0, 0, 3};
    vecs[4] = '{280, 85, 1, 2, 5, 4};
    vecs[5] = '{494, 124, 1, 3, 9, 4};
    vecs[6] = '{495, 35, 0, 0, 0, 3};
    vecs[7] = '{50, 124, 1, 3, 0, 4};
    vecs[8] = '{89, 49, 0, 0, 0, 3};
    vecs[9] = '{94, 30, 0, 0, 0, 3};

    reset = 1'b1; level_start = 1'b0; hit_req = 1'b0;
    hit_x = '0; hit_y = '0; hCount = '0; vCount = '0;
    score_m = 0; model_reload();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(hit_busy), 32'd0);
    check("rst_ack", 32'(hit_ack), 32'd0);
    check("rst_valid", 32'(hit_valid), 32'd0);
    check("rst_row_col", {26'd0, hit_row, hit_col}, 32'd0);
    check("rst_block_on", 32'(block_on), 32'd0);
    check("rst_pix_row", 32'(pix_row), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_blocks_left", 32'(blocks_left), 32'd40);
    check("rst_level_clear", 32'(level_clear), 32'd0);
    reset = 1'b0;

    render_check(60, 110);
    check("render_row3", 32'(pix_row), 32'd3);
    render_check(55, 35);
    check("render_row0_on", 32'(block_on), 32'd1);

    for (int i = 0; i < 10; i++) begin
      probe(vecs[i].x, vecs[i].y, lat, v, row, col);
      check("vec_latency", 32'(lat), 32'(vecs[i].lat));
      check("vec_valid", 32'(v), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check("vec_row", 32'(row), 32'(vecs[i].row));
        check("vec_col", 32'(col), 32'(vecs[i].col));
      end
      if (i == 0) begin
        check("first_left", 32'(blocks_left), 32'd39);
`ifdef BREAKOUT_ROW_SCORE_EN
        check("first_score", 32'(score), 32'd4);
`else
        check("first_score", 32'(score), 32'd1);
`endif
        check("render_after_clear", 32'(block_on), 32'd0);
      end
    end

    // hit_req held high throughout the busy window must not start a second probe.
    hit_req = 1'b1; hit_x = 10'd145; hit_y = 10'd35;
    @(negedge clk);
    hit_x = 10'd100; acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (hit_ack === 1'b1) acks++;
    end
    hit_req = 1'b0;
    count_acks(8, lat);
    acks += lat;
    alive_m[2] = 1'b0; left_m--; score_m += points(0);
    check("busy_req_single_ack", 32'(acks), 32'd1);
    check("busy_req_left", 32'(blocks_left), 32'(left_m));
    $display("busy-ignore acks=%0d left=%0d", acks, blocks_left);
    render_check(100, 35);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        x = 50 + 45 * $urandom_range(0, 9) + 20;
        y = 30 + 25 * $urandom_range(0, 3) + 10;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      probe(x, y, lat, v, row, col);
      render_check($urandom_range(0, 520), $urandom_range(0, 140));
    end

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 10; c++) begin
        prev_left = left_m;
        probe(50 + 45 * c + 20, 30 + 25 * r + 10, lat, v, row, col);
        if (prev_left == 1 && left_m == 0) begin
          check("zero_left_cycle", 32'(bl0_cyc), 32'd3);
          check("level_clear_cycle", 32'(lc_cyc), 32'd4);
        end
      end
    end
    check("all_clear_left", 32'(blocks_left), 32'd0);
    check("all_clear_flag", 32'(level_clear), 32'd1);

    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
    model_reload();
    check("reload_left", 32'(blocks_left), 32'd40);
    check("reload_clear", 32'(level_clear), 32'd0);
    check("reload_score", 32'(score), 32'(score_m));
    $display("level_start left=%0d level_clear=%0d score=%0d", blocks_left, level_clear, score);

    // level_start landing while the probe is in TEST aborts it.
    hit_req = 1'b1; hit_x = 10'd55; hit_y = 10'd35;
    @(negedge clk);
    hit_req = 1'b0;
    @(negedge clk);
    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
    check("abort_busy", 32'(hit_busy), 32'd0);
    count_acks(6, acks);
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_left", 32'(blocks_left), 32'd40);
    check("abort_score", 32'(score), 32'(score_m));
    $display("abort-in-test acks=%0d left=%0d", acks, blocks_left);
    render_check(55, 35);

    level_start = 1'b1; hit_req = 1'b1; hit_x = 10'd100; hit_y = 10'd35;
    @(negedge clk);
    level_start = 1'b0; hit_req = 1'b0;
    check("same_cycle_busy", 32'(hit_busy), 32'd0);
    count_acks(6, acks);
    check("same_cycle_no_ack", 32'(acks), 32'd0);
    check("same_cycle_left", 32'(blocks_left), 32'd40);
    $display("level_start+hit_req acks=%0d left=%0d", acks, blocks_left);

    hit_req = 1'b1; hit_x = 10'd100; hit_y = 10'd35;
    @(negedge clk);
    hit_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    score_m = 0; model_reload();
    check("midreset_busy", 32'(hit_busy), 32'd0);
    count_acks(6, acks);
    check("midreset_no_ack", 32'(acks), 32'd0);
    check("midreset_left", 32'(blocks_left), 32'd40);
    check("midreset_score", 32'(score), 32'd0);
    $display("reset-mid-probe acks=%0d left=%0d score=%0d", acks, blocks_left, score);
    probe(100, 35, lat, v, row, col);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
